// File: rtl/xvga_timing_gen.sv
// Raster timing generator for the 1024x768 display path: scan counters, aligned
// and pipeline-delayed sync/blank, and frame-boundary signalling.
module xvga_timing_gen #(
  parameter int H_ACTIVE        = 1024,
  parameter int H_FP            = 24,
  parameter int H_SYNC          = 136,
  parameter int H_BP            = 160,
  parameter int V_ACTIVE        = 768,
  parameter int V_FP            = 3,
  parameter int V_SYNC          = 6,
  parameter int V_BP            = 29,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int PIPE_DELAY      = 1
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        blank_d,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048) begin : g_h_total_check
    $error("xvga_timing_gen: H_TOTAL exceeds the 11-bit hcount range");
  end
  if (V_TOTAL > 1024) begin : g_v_total_check
    $error("xvga_timing_gen: V_TOTAL exceeds the 10-bit vcount range");
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_pipe_check
    $error("xvga_timing_gen: PIPE_DELAY must be in 1..4");
  end

  // One extra bit on the compare constants keeps an end-of-range bound of
  // exactly 2048/1024 from aliasing to zero.
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END    = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_OFF     = (SYNC_ACTIVE_LOW != 0);

  logic [10:0]           hcount_q, hcount_d;
  logic [9:0]            vcount_q, vcount_d;
  logic                  hs_q, hs_d;
  logic                  vs_q, vs_d;
  logic                  bl_q, bl_d;
  logic                  frame_start_q, frame_start_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
  logic [PIPE_DELAY-1:0] bl_pipe_q, bl_pipe_d;
  logic                  h_wrap, v_wrap;

  // NOTE: every signal gets a default at the top of always_comb, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    h_wrap        = (hcount_q == H_LAST);
    v_wrap        = (vcount_q == V_LAST);
    hcount_d      = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d      = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
    end

    // Decode from the next-state counters so the registered levels line up
    // with the position presented in the same cycle.
    hs_d = (({1'b0, hcount_d} >= H_SYNC_BEG) && ({1'b0, hcount_d} < H_SYNC_END))
           ? ~SYNC_OFF : SYNC_OFF;
    vs_d = (({1'b0, vcount_d} >= V_SYNC_BEG) && ({1'b0, vcount_d} < V_SYNC_END))
           ? ~SYNC_OFF : SYNC_OFF;
    bl_d = ({1'b0, hcount_d} >= H_ACT_END) || ({1'b0, vcount_d} >= V_ACT_END);

    frame_start_d = h_wrap && v_wrap;
    frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;

    hs_pipe_d = PIPE_DELAY'({hs_pipe_q, hs_q});
    vs_pipe_d = PIPE_DELAY'({vs_pipe_q, vs_q});
    bl_pipe_d = PIPE_DELAY'({bl_pipe_q, bl_q});
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; the delay pipelines are reset too so a mid-frame reset
  // flushes stale sync levels off the monitor interface.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hs_q          <= SYNC_OFF;
      vs_q          <= SYNC_OFF;
      bl_q          <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      hs_pipe_q     <= {PIPE_DELAY{SYNC_OFF}};
      vs_pipe_q     <= {PIPE_DELAY{SYNC_OFF}};
      bl_pipe_q     <= '0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      bl_q          <= bl_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      bl_pipe_q     <= bl_pipe_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign blank       = bl_q;
  assign hsync_d     = hs_pipe_q[PIPE_DELAY-1];
  assign vsync_d     = vs_pipe_q[PIPE_DELAY-1];
  assign blank_d     = bl_pipe_q[PIPE_DELAY-1];
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Scoreboard bench for xvga_timing_gen: a default 1024x768 instance and a
// shrunken active-high, PIPE_DELAY=3 instance, both reset at random points.
module tb_xvga_timing_gen;

  typedef struct packed {
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        hsd;
    logic        vsd;
    logic        bld;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    bit act_low;
    int pd;
  } cfg_t;

  cfg_t cfg_a = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b1, 1};
  cfg_t cfg_b = '{16, 2, 3, 3, 8, 1, 2, 1, 1'b0, 3};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [10:0] hc_a, hc_b;
  logic [9:0]  vc_a, vc_b;
  logic        hs_a, vs_a, bl_a, hsd_a, vsd_a, bld_a, fs_a;
  logic        hs_b, vs_b, bl_b, hsd_b, vsd_b, bld_b, fs_b;
  logic [15:0] fc_a, fc_b;

  xvga_timing_gen dut_a (
    .pixel_clk(clk), .reset_n(reset_n),
    .hcount(hc_a), .vcount(vc_a), .hsync(hs_a), .vsync(vs_a), .blank(bl_a),
    .hsync_d(hsd_a), .vsync_d(vsd_a), .blank_d(bld_a),
    .frame_start(fs_a), .frame_count(fc_a)
  );

  xvga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_ACTIVE_LOW(0), .PIPE_DELAY(3)
  ) dut_b (
    .pixel_clk(clk), .reset_n(reset_n),
    .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b), .blank(bl_b),
    .hsync_d(hsd_b), .vsync_d(vsd_b), .blank_d(bld_b),
    .frame_start(fs_b), .frame_count(fc_b)
  );

  obs_t act_a, act_b;
  assign act_a = '{hc_a, vc_a, hs_a, vs_a, bl_a, hsd_a, vsd_a, bld_a, fs_a, fc_a};
  assign act_b = '{hc_b, vc_b, hs_b, vs_b, bl_b, hsd_b, vsd_b, bld_b, fs_b, fc_b};

  obs_t q_a[$];
  obs_t q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  longint n_cyc  = 0;

  // Sync/blank levels for the n-th position of the raster after reset release.
  function automatic void levels(input cfg_t c, input longint n,
                                 output logic hs, output logic vs, output logic bl);
    longint ht = c.ha + c.hfp + c.hsw + c.hbp;
    longint vt = c.va + c.vfp + c.vsw + c.vbp;
    longint h  = n % ht;
    longint v  = (n / ht) % vt;
    bit hon = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw);
    bit von = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw);
    hs = c.act_low ? !hon : hon;
    vs = c.act_low ? !von : von;
    bl = (h >= c.ha) || (v >= c.va);
  endfunction

  function automatic obs_t model(input cfg_t c, input longint n);
    obs_t   e;
    longint ht = c.ha + c.hfp + c.hsw + c.hbp;
    longint vt = c.va + c.vfp + c.vsw + c.vbp;
    longint ft = ht * vt;
    e.hc = 11'(n % ht);
    e.vc = 10'((n / ht) % vt);
    levels(c, n, e.hs, e.vs, e.bl);
    if (n >= c.pd) begin
      levels(c, n - c.pd, e.hsd, e.vsd, e.bld);
    end else begin
      e.hsd = c.act_low;
      e.vsd = c.act_low;
      e.bld = 1'b0;
    end
    e.fs = (n > 0) && (n % ft == 0);
    e.fc = 16'((n / ft) % 65536);
    return e;
  endfunction

  function automatic obs_t reset_vals(input cfg_t c);
    return '{11'd0, 10'd0, c.act_low, c.act_low, 1'b0,
             c.act_low, c.act_low, 1'b0, 1'b0, 16'd0};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle=%0d got=%p want=%p", name, n_cyc, got, want);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q_a.size() > 0) check("dut_a", act_a, q_a.pop_front());
    if (q_b.size() > 0) check("dut_b", act_b, q_b.pop_front());
  end

  task automatic run(input int k);
    repeat (k) begin
      @(posedge clk);
      n_cyc++;
      q_a.push_back(model(cfg_a, n_cyc));
      q_b.push_back(model(cfg_b, n_cyc));
    end
  endtask

  // Assert reset between edges, confirm the outputs fall to reset values
  // before any clock edge, hold it across an edge, then release.
  task automatic async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_a", act_a, reset_vals(cfg_a));
    check("async_reset_b", act_b, reset_vals(cfg_b));
    @(negedge clk);
    check("held_reset_a", act_a, reset_vals(cfg_a));
    check("held_reset_b", act_b, reset_vals(cfg_b));
    #2 reset_n = 1'b1;
    n_cyc = 0;
  endtask

  initial begin
    int wait_cyc;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("por_reset_a", act_a, reset_vals(cfg_a));
    check("por_reset_b", act_b, reset_vals(cfg_b));
    #2 reset_n = 1'b1;
    n_cyc = 0;

    run(3000);
    repeat (6) begin
      async_reset();
      run(int'($urandom_range(300, 1500)));
    end
    async_reset();
    run(700);

    wait_cyc = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && wait_cyc < 10) begin
      @(negedge clk);
      #1 wait_cyc++;
    end
    if (q_a.size() > 0 || q_b.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", q_a.size() + q_b.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
